// File: rtl/temperature_pkg.sv
// temperature_pkg: shared widths, FSM state encoding and reserved data codes
package temperature_pkg;
  localparam int SENSOR_DATA_W = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    REL     = 2'd2,
    PUBLISH = 2'd3
  } state_e;
  localparam logic [SENSOR_DATA_W-1:0] OPEN_CIRCUIT_CODE = 8'hFF;
  localparam logic [SENSOR_DATA_W-1:0] NO_REPLY_DATA     = 8'h00;
endpackage

// File: rtl/scan_period_timer.sv
// scan_period_timer: loadable up-counter that saturates at MAX_COUNT-1 and flags it
module scan_period_timer #(
  parameter int MAX_COUNT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_tc
);
  localparam int W = MAX_COUNT > 1 ? $clog2(MAX_COUNT) : 1;
  logic [W-1:0] r_count;
  assign o_tc = r_count == W'(MAX_COUNT - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else r_count <= i_load ? '0 : o_tc ? r_count : r_count + 1'b1;
endmodule

// File: rtl/sensor_scanner.sv
// sensor_scanner: polls sensors over a 4-phase req/ack bus and publishes coherent frames.
// Define SENSOR_RANGE_CHECK_EN to reject open-circuit and implausibly hot readings.
module sensor_scanner
  import temperature_pkg::*;
#(
  parameter int NR_OF_SENSORS  = 5,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SCAN_PERIOD    = 1000,
  parameter int MAX_VALID_TEMP = 150,
  localparam int SEL_W = NR_OF_SENSORS > 1 ? $clog2(NR_OF_SENSORS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   scan_en_i,
  output logic [SEL_W-1:0]                       sensor_sel_o,
  output logic                                   sensor_req_o,
  input  logic                                   sensor_ack_i,
  input  logic [SENSOR_DATA_W-1:0]               sensor_data_i,
  output logic [NR_OF_SENSORS*SENSOR_DATA_W-1:0] sensors_data_o,
  output logic [NR_OF_SENSORS-1:0]               sensors_en_o,
  output logic                                   frame_valid_o,
  output logic                                   busy_o
);
`ifdef SENSOR_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  localparam logic [SENSOR_DATA_W-1:0] MAX_T = SENSOR_DATA_W'(MAX_VALID_TEMP);
  state_e                             r_state;
  logic [SEL_W-1:0]                   r_idx;
  logic                               r_req, r_busy, r_valid;
  logic [NR_OF_SENSORS*SENSOR_DATA_W-1:0] r_shadow_data, r_data;
  logic [NR_OF_SENSORS-1:0]           r_shadow_en, r_en;
  logic                               w_period_tc, w_to_tc, w_start, w_req_done, w_rel_done;
  logic                               w_last, w_ok;
  logic [SENSOR_DATA_W-1:0]           w_capture;
  assign w_start    = r_state == IDLE && w_period_tc && scan_en_i;
  assign w_req_done = r_state == REQ && (sensor_ack_i || w_to_tc);
  assign w_rel_done = r_state == REL && (!sensor_ack_i || w_to_tc);
  assign w_last     = r_idx == SEL_W'(NR_OF_SENSORS - 1);
  // A rejected reading is indistinguishable from a sensor that never answered
  assign w_ok       = sensor_ack_i &&
                      (!RANGE_CHECK || (sensor_data_i != OPEN_CIRCUIT_CODE && sensor_data_i <= MAX_T));
  assign w_capture  = w_ok ? sensor_data_i : NO_REPLY_DATA;
  scan_period_timer #(.MAX_COUNT(SCAN_PERIOD)) u_period (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_load  (r_state != IDLE || w_start),
    .o_tc    (w_period_tc)
  );
  scan_period_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_load  (r_state == IDLE || r_state == PUBLISH || w_req_done || w_rel_done),
    .o_tc    (w_to_tc)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_req         <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_en   <= '0;
      r_data        <= '0;
      r_en          <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: if (w_start) begin
          r_state <= REQ;
          r_idx   <= '0;
          r_req   <= 1'b1;
          r_busy  <= 1'b1;
        end
        REQ: if (w_req_done) begin
          r_shadow_data[r_idx*SENSOR_DATA_W +: SENSOR_DATA_W] <= w_capture;
          r_shadow_en[r_idx] <= w_ok;
          r_state <= REL;
          r_req   <= 1'b0;
        end
        REL: if (w_rel_done) begin
          if (w_last) r_state <= PUBLISH;
          else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        PUBLISH: begin
          r_data  <= r_shadow_data;
          r_en    <= r_shadow_en;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  assign sensor_sel_o   = r_idx;
  assign sensor_req_o   = r_req;
  assign busy_o         = r_busy;
  assign frame_valid_o  = r_valid;
  assign sensors_data_o = r_data;
  assign sensors_en_o   = r_en;
endmodule

// File: tb/tb_sensor_scanner.sv
// tb_sensor_scanner: directed checks of sensor_scanner with a per-sensor behavioural responder.
// Expectations follow SENSOR_RANGE_CHECK_EN when it is defined for the build.
module tb_sensor_scanner;
  logic        clk = 1'b0;
  logic        rst_n, scan_en, ack;
  logic [7:0]  sdata;
  logic [2:0]  sel;
  logic        req, valid, busy;
  logic [39:0] data_o;
  logic [4:0]  en_o;
  int          delay[5];
  bit          stuck[5];
  logic [7:0]  val[5];
  int          req_cycles[8];
  int          rel_cycles[8];
  int          n_frames = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cnt = 0;

  sensor_scanner #(
    .NR_OF_SENSORS(5), .TIMEOUT_CYCLES(16), .SCAN_PERIOD(32), .MAX_VALID_TEMP(150)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scan_en_i(scan_en),
    .sensor_sel_o(sel), .sensor_req_o(req), .sensor_ack_i(ack), .sensor_data_i(sdata),
    .sensors_data_o(data_o), .sensors_en_o(en_o), .frame_valid_o(valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Selected sensor answers `delay` cycles into its request (0 = never); stuck acks never release
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0;
      ack = 1'b0;
    end else if (req) begin
      cnt++;
      ack = delay[int'(sel)] != 0 && cnt >= delay[int'(sel)];
    end else begin
      cnt = 0;
      if (!stuck[int'(sel)]) ack = 1'b0;
    end
    sdata = ack ? val[int'(sel)] : 8'hA5;
  end

  always @(negedge clk) begin
    if (req) req_cycles[sel]++;
    else if (busy) rel_cycles[sel]++;
    if (valid) n_frames++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic default_cfg();
    for (int i = 0; i < 5; i++) begin
      delay[i] = 2;
      stuck[i] = 1'b0;
      val[i]   = 8'(20 + i);
    end
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!valid && n < 2000);
    check("frame_seen", 64'(valid), 64'd1);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!req && n < 2000);
    check("req_seen", 64'(req), 64'd1);
  endtask

  initial begin
    int n, f0, b1, b3, b0, r2;
    for (int i = 0; i < 8; i++) begin
      req_cycles[i] = 0;
      rel_cycles[i] = 0;
    end
    rst_n = 1'b0;
    scan_en = 1'b0;
    ack = 1'b0;
    sdata = 8'h00;
    default_cfg();
    repeat (3) @(negedge clk);
    check("reset_data", 64'(data_o), 64'd0);
    check("reset_en", 64'(en_o), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_req", 64'(req), 64'd0);
    rst_n = 1'b1;
    // Scan held off by scan_en, then starts on the first enabled cycle
    repeat (100) @(negedge clk);
    check("idle_no_req", 64'(req), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);
    scan_en = 1'b1;
    @(posedge clk); #1;
    check("req_after_enable", 64'(req), 64'd1);
    check("first_sel", 64'(sel), 64'd0);
    wait_frame(n);
    check("scan_length", 64'(n), 64'd16);
    check("all_ok_data", 64'(data_o), 64'h18_17_16_15_14);
    check("all_ok_en", 64'(en_o), 64'b11111);
    @(negedge clk); #1;
    check("one_frame", 64'(n_frames), 64'd1);
    @(posedge clk); #1;
    check("valid_one_cycle", 64'(valid), 64'd0);
    // Sensors 1 and 3 silent
    delay[1] = 0;
    delay[3] = 0;
    b0 = req_cycles[0];
    b1 = req_cycles[1];
    b3 = req_cycles[3];
    wait_req(n);
    check("idle_gap", 64'(n + 1), 64'd32);
    wait_frame(n);
    check("silent_en", 64'(en_o), 64'b10101);
    check("silent_data", 64'(data_o), 64'h18_00_16_00_14);
    check("silent_req1_cycles", 64'(req_cycles[1] - b1), 64'd16);
    check("silent_req3_cycles", 64'(req_cycles[3] - b3), 64'd16);
    check("ok_req0_cycles", 64'(req_cycles[0] - b0), 64'd2);
    // Sensor 2 never releases ack
    default_cfg();
    stuck[2] = 1'b1;
    r2 = rel_cycles[2];
    wait_frame(n);
    check("stuck_rel_cycles", 64'(rel_cycles[2] - r2), 64'd16);
    check("stuck_en", 64'(en_o), 64'b11111);
    check("stuck_data", 64'(data_o), 64'h18_17_16_15_14);
    // Ack exactly on the timeout cycle wins; one cycle later is too late
    default_cfg();
    delay[0] = 16;
    delay[4] = 17;
    wait_frame(n);
    check("late_ack_en", 64'(en_o), 64'b01111);
    check("late_ack_data", 64'(data_o), 64'h00_17_16_15_14);
    // Plausibility boundary readings
    default_cfg();
    val[0] = 8'd150;
    val[1] = 8'hFF;
    val[3] = 8'd200;
    val[4] = 8'd151;
    wait_frame(n);
`ifdef SENSOR_RANGE_CHECK_EN
    check("range_en", 64'(en_o), 64'b00101);
    check("range_data", 64'(data_o), 64'h00_00_16_00_96);
`else
    check("range_en", 64'(en_o), 64'b11111);
    check("range_data", 64'(data_o), 64'h97_C8_16_FF_96);
`endif
    // Reset in the middle of a scan
    default_cfg();
    n = 0;
    while (!(req && sel == 3'd3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_idx3", 64'(req && sel == 3'd3), 64'd1);
    f0 = n_frames;
    rst_n = 1'b0;
    #1;
    check("midreset_data", 64'(data_o), 64'd0);
    check("midreset_en", 64'(en_o), 64'd0);
    check("midreset_req", 64'(req), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("no_partial_frame", 64'(n_frames - f0), 64'd0);
    check("outputs_still_zero", 64'(en_o), 64'd0);
    wait_frame(n);
    check("rescan_data", 64'(data_o), 64'h18_17_16_15_14);
    check("rescan_en", 64'(en_o), 64'b11111);
    @(negedge clk); #1;
    check("rescan_one_frame", 64'(n_frames - f0), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
